ibex_rvfi_trace_buffer: RTL and testbench

- Parametrised post-mortem trace capture block fed by the core's RVFI retire stream, in the tracing top alongside the text tracer.
- Continuously records retired-instruction records into a circular buffer once armed.
- Freezes a configurable number of records after a trigger (manual, PC match, trap or interrupt).
- Then drains the frozen window oldest-first over a valid/ready read port, making traces available in silicon/FPGA where the simulation-only tracer is absent.

---
 rtl/ibex_rvfi_trace_buffer.sv | 198 +++++++++++++++++++
 tb/tb_ibex_rvfi_trace_buffer.sv | 518 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_rvfi_trace_buffer.sv
// ---------------------------------------------------------------------------
// ibex_rvfi_trace_buffer
//
// Post-mortem trace capture fed by the RVFI retire stream. Once armed, every
// retired instruction is written into a circular buffer. The oldest record is
// overwritten when the buffer is full. A trigger (manual, PC match, trap or
// interrupt) freezes the window after PostTrig further records. The frozen
// window is then drained oldest-first over a valid/ready read port.
//
// Record layout: [31:0] pc, [63:32] insn, [64] trap, [65] intr, [67:66] mode,
// and when CaptureMem: [99:68] mem_addr, [103:100] rmask, [107:104] wmask.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   rvfi_*_i              retire stream (mem fields used only if CaptureMem)
//   arm_i                 pulse: clear buffer and start capturing
//   trig_mode_i           0 manual, 1 PC match, 2 trap, 3 interrupt
//   trig_pc_i             PC compare value for mode 1
//   trig_now_i            manual trigger, honoured in every mode
//   rd_valid_o/rd_ready_i read handshake, active only once capture is frozen
//   rd_data_o             oldest stored record
//   count_o               records currently stored
//   state_o               0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   wrapped_o             sticky: a record was overwritten since arm
// ---------------------------------------------------------------------------
module ibex_rvfi_trace_buffer #(
    parameter int unsigned  Depth      = 16,
    parameter int unsigned  PostTrig   = 4,
    parameter bit           CaptureMem = 1'b0,
    localparam int unsigned RecW       = 68 + (CaptureMem ? 40 : 0),
    localparam int unsigned CntW       = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            rvfi_valid_i,
    input  logic [31:0]     rvfi_pc_rdata_i,
    input  logic [31:0]     rvfi_insn_i,
    input  logic            rvfi_trap_i,
    input  logic            rvfi_intr_i,
    input  logic [1:0]      rvfi_mode_i,
    input  logic [31:0]     rvfi_mem_addr_i,
    input  logic [3:0]      rvfi_mem_rmask_i,
    input  logic [3:0]      rvfi_mem_wmask_i,
    input  logic            arm_i,
    input  logic [1:0]      trig_mode_i,
    input  logic [31:0]     trig_pc_i,
    input  logic            trig_now_i,
    output logic            rd_valid_o,
    input  logic            rd_ready_i,
    output logic [RecW-1:0] rd_data_o,
    output logic [CntW-1:0] count_o,
    output logic [1:0]      state_o,
    output logic            wrapped_o
);

    localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned PW = (PostTrig > 0) ? $clog2(PostTrig + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [RecW-1:0] r_mem [Depth];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CntW-1:0] r_count;
    logic [PW-1:0]   r_post;
    logic            r_wrapped;

    logic [RecW-1:0] w_rec;
    logic            w_capturing;
    logic            w_store;
    logic            w_full;
    logic            w_match;
    logic            w_trig;
    logic            w_pop;

    generate
        if (CaptureMem) begin : g_mem
            assign w_rec = {rvfi_mem_wmask_i, rvfi_mem_rmask_i, rvfi_mem_addr_i,
                            rvfi_mode_i, rvfi_intr_i, rvfi_trap_i,
                            rvfi_insn_i, rvfi_pc_rdata_i};
        end else begin : g_nomem
            // Memory fields are deliberately dropped in this configuration.
            logic w_unused_mem;
            assign w_unused_mem = ^{rvfi_mem_addr_i, rvfi_mem_rmask_i, rvfi_mem_wmask_i};
            assign w_rec = {rvfi_mode_i, rvfi_intr_i, rvfi_trap_i,
                            rvfi_insn_i, rvfi_pc_rdata_i};
        end
    endgenerate

    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_match = 1'b0;
        unique case (trig_mode_i)
            2'd1:    w_match = (rvfi_pc_rdata_i == trig_pc_i);
            2'd2:    w_match = rvfi_trap_i;
            2'd3:    w_match = rvfi_intr_i;
            default: w_match = 1'b0;
        endcase
    end

    assign w_capturing = (r_state == ST_ARMED) || (r_state == ST_POST);
    // arm and reset both discard anything retiring in the same cycle.
    assign w_store     = rvfi_valid_i && w_capturing && !arm_i && !rst_i;
    assign w_full      = (r_count == CntW'(Depth));
    assign w_trig      = (r_state == ST_ARMED) && (trig_now_i || (rvfi_valid_i && w_match));
    assign w_pop       = (r_state == ST_DONE) && (r_count != '0) && rd_ready_i;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_ARMED: begin
                if (w_trig) begin
                    w_state_next = (PostTrig == 0) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                // r_post is at least 1 while in POST; the last post-trigger
                // record freezes the window.
                if (rvfi_valid_i && (r_post == PW'(1))) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_pop && (r_count == CntW'(1))) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = r_state;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_post    <= '0;
            r_wrapped <= 1'b0;
        end else if (arm_i) begin
            r_state   <= ST_ARMED;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_post    <= '0;
            r_wrapped <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Store and pop never coincide: stores happen only while
            // capturing, pops only once frozen.
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_full) begin
                    // Full: the write lands on the oldest slot, so the read
                    // pointer steps past it and the count stays at Depth.
                    r_rd_ptr  <= r_rd_ptr + AW'(1);
                    r_wrapped <= 1'b1;
                end else begin
                    r_count <= r_count + CntW'(1);
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_count  <= r_count - CntW'(1);
            end
            if (w_trig) begin
                r_post <= PW'(PostTrig);
            end else if ((r_state == ST_POST) && rvfi_valid_i) begin
                r_post <= r_post - PW'(1);
            end
        end
    end

    // NOTE: the record array has no reset; count and pointers alone define
    // which entries are meaningful, and skipping the reset keeps it a RAM.
    always_ff @(posedge clk_i) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= w_rec;
        end
    end

    assign rd_valid_o = (r_state == ST_DONE) && (r_count != '0);
    assign rd_data_o  = r_mem[r_rd_ptr];
    assign count_o    = r_count;
    assign state_o    = r_state;
    assign wrapped_o  = r_wrapped;

endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_ibex_rvfi_trace_buffer
//
// Three instances share one stimulus stream:
//   u0: Depth 16, PostTrig 4, CaptureMem 1
//   u1: Depth 8,  PostTrig 2, CaptureMem 0
//   u2: Depth 4,  PostTrig 0, CaptureMem 0
// A queue-based reference model per instance is advanced on every clock and
// compared with all outputs. Scenario tasks add directed checks on the
// instance each scenario is aimed at.
// ---------------------------------------------------------------------------
module tb_ibex_rvfi_trace_buffer;

    typedef logic [107:0] rec_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        rvfi_valid_i;
    logic [31:0] rvfi_pc_rdata_i;
    logic [31:0] rvfi_insn_i;
    logic        rvfi_trap_i;
    logic        rvfi_intr_i;
    logic [1:0]  rvfi_mode_i;
    logic [31:0] rvfi_mem_addr_i;
    logic [3:0]  rvfi_mem_rmask_i;
    logic [3:0]  rvfi_mem_wmask_i;
    logic        arm_i;
    logic [1:0]  trig_mode_i;
    logic [31:0] trig_pc_i;
    logic        trig_now_i;
    logic        rd_ready_i;

    logic         vld [3];
    logic         wr  [3];
    logic [1:0]   st  [3];
    logic [107:0] d0;
    logic [67:0]  d1, d2;
    logic [4:0]   c0;
    logic [3:0]   c1;
    logic [2:0]   c2;
    rec_t         obs_data [3];
    logic [31:0]  obs_cnt  [3];

    assign obs_data[0] = d0;
    assign obs_data[1] = {40'b0, d1};
    assign obs_data[2] = {40'b0, d2};
    assign obs_cnt[0]  = 32'(c0);
    assign obs_cnt[1]  = 32'(c1);
    assign obs_cnt[2]  = 32'(c2);

    always #5 clk_i = ~clk_i;

    ibex_rvfi_trace_buffer #(.Depth(16), .PostTrig(4), .CaptureMem(1'b1)) u0 (
        .clk_i(clk_i), .rst_i(rst_i), .rvfi_valid_i(rvfi_valid_i),
        .rvfi_pc_rdata_i(rvfi_pc_rdata_i), .rvfi_insn_i(rvfi_insn_i),
        .rvfi_trap_i(rvfi_trap_i), .rvfi_intr_i(rvfi_intr_i), .rvfi_mode_i(rvfi_mode_i),
        .rvfi_mem_addr_i(rvfi_mem_addr_i), .rvfi_mem_rmask_i(rvfi_mem_rmask_i),
        .rvfi_mem_wmask_i(rvfi_mem_wmask_i), .arm_i(arm_i), .trig_mode_i(trig_mode_i),
        .trig_pc_i(trig_pc_i), .trig_now_i(trig_now_i), .rd_valid_o(vld[0]),
        .rd_ready_i(rd_ready_i), .rd_data_o(d0), .count_o(c0), .state_o(st[0]),
        .wrapped_o(wr[0]));

    ibex_rvfi_trace_buffer #(.Depth(8), .PostTrig(2), .CaptureMem(1'b0)) u1 (
        .clk_i(clk_i), .rst_i(rst_i), .rvfi_valid_i(rvfi_valid_i),
        .rvfi_pc_rdata_i(rvfi_pc_rdata_i), .rvfi_insn_i(rvfi_insn_i),
        .rvfi_trap_i(rvfi_trap_i), .rvfi_intr_i(rvfi_intr_i), .rvfi_mode_i(rvfi_mode_i),
        .rvfi_mem_addr_i(rvfi_mem_addr_i), .rvfi_mem_rmask_i(rvfi_mem_rmask_i),
        .rvfi_mem_wmask_i(rvfi_mem_wmask_i), .arm_i(arm_i), .trig_mode_i(trig_mode_i),
        .trig_pc_i(trig_pc_i), .trig_now_i(trig_now_i), .rd_valid_o(vld[1]),
        .rd_ready_i(rd_ready_i), .rd_data_o(d1), .count_o(c1), .state_o(st[1]),
        .wrapped_o(wr[1]));

    ibex_rvfi_trace_buffer #(.Depth(4), .PostTrig(0), .CaptureMem(1'b0)) u2 (
        .clk_i(clk_i), .rst_i(rst_i), .rvfi_valid_i(rvfi_valid_i),
        .rvfi_pc_rdata_i(rvfi_pc_rdata_i), .rvfi_insn_i(rvfi_insn_i),
        .rvfi_trap_i(rvfi_trap_i), .rvfi_intr_i(rvfi_intr_i), .rvfi_mode_i(rvfi_mode_i),
        .rvfi_mem_addr_i(rvfi_mem_addr_i), .rvfi_mem_rmask_i(rvfi_mem_rmask_i),
        .rvfi_mem_wmask_i(rvfi_mem_wmask_i), .arm_i(arm_i), .trig_mode_i(trig_mode_i),
        .trig_pc_i(trig_pc_i), .trig_now_i(trig_now_i), .rd_valid_o(vld[2]),
        .rd_ready_i(rd_ready_i), .rd_data_o(d2), .count_o(c2), .state_o(st[2]),
        .wrapped_o(wr[2]));

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a queue of stored records per instance; the oldest
    // record is the queue front. States use the externally visible codes.
    int   m_depth [3] = '{16, 8, 4};
    int   m_pt    [3] = '{4, 2, 0};
    int   m_rw    [3] = '{108, 68, 68};
    int   m_state [3] = '{0, 0, 0};
    int   m_post  [3] = '{0, 0, 0};
    bit   m_wrap  [3] = '{1'b0, 1'b0, 1'b0};
    rec_t q0[$], q1[$], q2[$];
    rec_t sent[$];   // records applied since the last arm, in order

    function automatic int qsize(int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic rec_t qfront(int k);
        case (k)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    function automatic void qpush(int k, rec_t r);
        case (k)
            0:       q0.push_back(r);
            1:       q1.push_back(r);
            default: q2.push_back(r);
        endcase
    endfunction

    function automatic void qpop(int k);
        case (k)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endfunction

    function automatic void qclear(int k);
        case (k)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endfunction

    function automatic rec_t rmask(int k);
        rec_t m = '1;
        if (m_rw[k] == 68) m[107:68] = '0;
        return m;
    endfunction

    function automatic rec_t cur_rec();
        return {rvfi_mem_wmask_i, rvfi_mem_rmask_i, rvfi_mem_addr_i, rvfi_mode_i,
                rvfi_intr_i, rvfi_trap_i, rvfi_insn_i, rvfi_pc_rdata_i};
    endfunction

    function automatic void m_store(int k, rec_t r);
        qpush(k, r);
        if (qsize(k) > m_depth[k]) begin
            qpop(k);
            m_wrap[k] = 1'b1;
        end
    endfunction

    task automatic model_step();
        rec_t r = cur_rec();
        for (int k = 0; k < 3; k++) begin
            bit hit;
            hit = trig_now_i ||
                  (rvfi_valid_i && ((trig_mode_i == 2'd1 && rvfi_pc_rdata_i == trig_pc_i) ||
                                    (trig_mode_i == 2'd2 && rvfi_trap_i) ||
                                    (trig_mode_i == 2'd3 && rvfi_intr_i)));
            if (rst_i || arm_i) begin
                m_state[k] = rst_i ? 0 : 1;
                m_post[k]  = 0;
                m_wrap[k]  = 1'b0;
                qclear(k);
            end else begin
                case (m_state[k])
                    1: begin
                        if (rvfi_valid_i) m_store(k, r);
                        if (hit) begin
                            if (m_pt[k] == 0) m_state[k] = 3;
                            else begin
                                m_state[k] = 2;
                                m_post[k]  = m_pt[k];
                            end
                        end
                    end
                    2: begin
                        if (rvfi_valid_i) begin
                            m_store(k, r);
                            m_post[k] = m_post[k] - 1;
                            if (m_post[k] == 0) m_state[k] = 3;
                        end
                    end
                    3: begin
                        if (qsize(k) != 0 && rd_ready_i) begin
                            qpop(k);
                            if (qsize(k) == 0) m_state[k] = 0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    // One clock: advance the model with the inputs present at the edge, then
    // compare every instance against it.
    task automatic cycle();
        @(posedge clk_i);
        model_step();
        #1;
        for (int k = 0; k < 3; k++) begin
            logic exp_v;
            exp_v = (m_state[k] == 3) && (qsize(k) != 0);
            n_checks++;
            if (st[k] !== 2'(m_state[k]) || obs_cnt[k] !== 32'(qsize(k)) ||
                wr[k] !== m_wrap[k] || vld[k] !== exp_v) begin
                n_errors++;
                $display("FAIL model_ctrl u%0d t=%0t: state=%0d count=%0d wrapped=%b valid=%b, expected state=%0d count=%0d wrapped=%b valid=%b",
                         k, $time, st[k], obs_cnt[k], wr[k], vld[k],
                         m_state[k], qsize(k), m_wrap[k], exp_v);
            end
            if (exp_v) begin
                n_checks++;
                if ((obs_data[k] & rmask(k)) !== (qfront(k) & rmask(k))) begin
                    n_errors++;
                    $display("FAIL model_data u%0d t=%0t: got %h expected %h",
                             k, $time, obs_data[k] & rmask(k), qfront(k) & rmask(k));
                end
            end
        end
    endtask

    task automatic retire(input logic [31:0] pc, input bit trap, input bit intr, input bit tnow);
        rvfi_valid_i     = 1'b1;
        rvfi_pc_rdata_i  = pc;
        rvfi_insn_i      = $urandom;
        rvfi_trap_i      = trap;
        rvfi_intr_i      = intr;
        rvfi_mode_i      = 2'($urandom_range(0, 3));
        rvfi_mem_addr_i  = $urandom;
        rvfi_mem_rmask_i = 4'($urandom_range(0, 15));
        rvfi_mem_wmask_i = 4'($urandom_range(0, 15));
        trig_now_i       = tnow;
        sent.push_back(cur_rec());
        cycle();
        rvfi_valid_i = 1'b0;
        trig_now_i   = 1'b0;
    endtask

    task automatic do_arm(input logic [1:0] mode);
        trig_mode_i = mode;
        rd_ready_i  = 1'b0;
        arm_i       = 1'b1;
        cycle();
        arm_i = 1'b0;
        sent.delete();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (st[k] !== 2'd0 || obs_cnt[k] !== 32'd0 || wr[k] !== 1'b0 || vld[k] !== 1'b0) begin
                n_errors++;
                $display("FAIL reset u%0d: state=%0d count=%0d wrapped=%b valid=%b, expected 0 0 0 0",
                         k, st[k], obs_cnt[k], wr[k], vld[k]);
            end
        end
        // Retires while idle are ignored.
        retire(32'h40, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (st[0] !== 2'd0 || c0 !== 5'd0) begin
            n_errors++;
            $display("FAIL idle_ignore: state=%0d count=%0d, expected 0 0", st[0], c0);
        end
    endtask

    task automatic test_pc_match();
        trig_pc_i = 32'h100;
        do_arm(2'd1);
        for (int i = 0; i < 13; i++) retire(32'h0F0 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (st[0] !== 2'd3 || c0 !== 5'd9 || wr[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL pc_match_done: state=%0d count=%0d wrapped=%b, expected 3 9 0", st[0], c0, wr[0]);
        end
        rd_ready_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (vld[0] !== 1'b1 || d0[31:0] !== 32'h0F0 + 32'(4 * i) || c0 !== 5'(9 - i)) begin
                n_errors++;
                $display("FAIL pc_match_drain[%0d]: valid=%b pc=%h count=%0d, expected 1 %h %0d",
                         i, vld[0], d0[31:0], c0, 32'h0F0 + 32'(4 * i), 9 - i);
            end
            n_checks++;
            if (d0[107:68] !== sent[i][107:68]) begin
                n_errors++;
                $display("FAIL capture_mem[%0d]: got %h expected %h", i, d0[107:68], sent[i][107:68]);
            end
            cycle();
        end
        rd_ready_i = 1'b0;
        n_checks++;
        if (st[0] !== 2'd0 || c0 !== 5'd0 || vld[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL pc_match_empty: state=%0d count=%0d valid=%b, expected 0 0 0", st[0], c0, vld[0]);
        end
    endtask

    task automatic test_wrap();
        do_arm(2'd2);
        for (int i = 0; i < 20; i++) retire(32'h1000 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        retire(32'h200, 1'b1, 1'b0, 1'b0);
        retire(32'h204, 1'b0, 1'b0, 1'b0);
        retire(32'h208, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (st[1] !== 2'd3 || c1 !== 4'd8 || wr[1] !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_done: state=%0d count=%0d wrapped=%b, expected 3 8 1", st[1], c1, wr[1]);
        end
        rd_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] exp_pc;
            exp_pc = (i < 5) ? 32'h103C + 32'(4 * i) : 32'h200 + 32'(4 * (i - 5));
            n_checks++;
            if (vld[1] !== 1'b1 || d1[31:0] !== exp_pc) begin
                n_errors++;
                $display("FAIL wrap_drain[%0d]: valid=%b pc=%h, expected 1 %h", i, vld[1], d1[31:0], exp_pc);
            end
            cycle();
        end
        rd_ready_i = 1'b0;
        n_checks++;
        if (st[1] !== 2'd0 || wr[1] !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_sticky: state=%0d wrapped=%b, expected 0 1", st[1], wr[1]);
        end
    endtask

    task automatic test_intr();
        do_arm(2'd3);
        retire(32'h74, 1'b0, 1'b0, 1'b0);
        retire(32'h78, 1'b1, 1'b0, 1'b0);
        retire(32'h7C, 1'b0, 1'b0, 1'b0);
        retire(32'h80, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (st[2] !== 2'd3 || c2 !== 3'd4) begin
            n_errors++;
            $display("FAIL intr_done: state=%0d count=%0d, expected 3 4", st[2], c2);
        end
        rd_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (vld[2] !== 1'b1 || d2 !== sent[i][67:0]) begin
                n_errors++;
                $display("FAIL intr_drain[%0d]: valid=%b data=%h, expected 1 %h", i, vld[2], d2, sent[i][67:0]);
            end
            if (i == 3) begin
                n_checks++;
                if (d2[31:0] !== 32'h80 || d2[65] !== 1'b1) begin
                    n_errors++;
                    $display("FAIL intr_last: pc=%h intr=%b, expected 00000080 1", d2[31:0], d2[65]);
                end
            end
            cycle();
        end
        rd_ready_i = 1'b0;
    endtask

    task automatic test_manual();
        do_arm(2'd0);
        for (int i = 0; i < 3; i++) retire(32'h500 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        trig_now_i = 1'b1;
        cycle();
        trig_now_i = 1'b0;
        n_checks++;
        if (st[0] !== 2'd2 || c0 !== 5'd3) begin
            n_errors++;
            $display("FAIL manual_post: state=%0d count=%0d, expected 2 3", st[0], c0);
        end
        for (int i = 0; i < 4; i++) retire(32'h600 + 32'(4 * i), 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (st[0] !== 2'd3 || c0 !== 5'd7) begin
            n_errors++;
            $display("FAIL manual_done: state=%0d count=%0d, expected 3 7", st[0], c0);
        end
        arm_i      = 1'b1;
        trig_now_i = 1'b1;
        cycle();
        arm_i      = 1'b0;
        trig_now_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (st[k] !== 2'd1 || obs_cnt[k] !== 32'd0 || wr[k] !== 1'b0) begin
                n_errors++;
                $display("FAIL arm_wins u%0d: state=%0d count=%0d wrapped=%b, expected 1 0 0",
                         k, st[k], obs_cnt[k], wr[k]);
            end
        end
    endtask

    task automatic test_back_to_back_stall();
        int idx = 0;
        do_arm(2'd0);
        retire(32'h300, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i < 5; i++) retire(32'h300 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (st[0] !== 2'd3 || c0 !== 5'd5) begin
            n_errors++;
            $display("FAIL stall_done: state=%0d count=%0d, expected 3 5", st[0], c0);
        end
        for (int j = 0; j < 4; j++) begin
            rd_ready_i = (j % 2 == 0);
            cycle();
            if (rd_ready_i) idx++;
            n_checks++;
            if (vld[0] !== 1'b1 || d0 !== sent[idx] || c0 !== 5'(5 - idx)) begin
                n_errors++;
                $display("FAIL stall[%0d]: valid=%b pc=%h count=%0d, expected 1 %h %0d",
                         j, vld[0], d0[31:0], c0, sent[idx][31:0], 5 - idx);
            end
        end
        rd_ready_i = 1'b1;
        arm_i      = 1'b1;
        cycle();
        arm_i      = 1'b0;
        rd_ready_i = 1'b0;
        n_checks++;
        if (c0 !== 5'd0 || vld[0] !== 1'b0 || st[0] !== 2'd1) begin
            n_errors++;
            $display("FAIL abort_drain: count=%0d valid=%b state=%0d, expected 0 0 1", c0, vld[0], st[0]);
        end
    endtask

    task automatic test_reset_in_post();
        do_arm(2'd0);
        for (int i = 0; i < 18; i++) retire(32'h700 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        retire(32'h800, 1'b0, 1'b0, 1'b1);
        retire(32'h804, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (st[0] !== 2'd2 || wr[0] !== 1'b1 || c0 !== 5'd16) begin
            n_errors++;
            $display("FAIL post_wrapped: state=%0d wrapped=%b count=%0d, expected 2 1 16", st[0], wr[0], c0);
        end
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (st[k] !== 2'd0 || obs_cnt[k] !== 32'd0 || wr[k] !== 1'b0 || vld[k] !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_in_post u%0d: state=%0d count=%0d wrapped=%b valid=%b, expected 0 0 0 0",
                         k, st[k], obs_cnt[k], wr[k], vld[k]);
            end
        end
    endtask

    task automatic test_random();
        trig_pc_i = 32'($urandom_range(0, 255)) << 2;
        do_arm(2'($urandom_range(0, 3)));
        for (int i = 0; i < 3000; i++) begin
            rst_i            = ($urandom_range(0, 399) == 0);
            arm_i            = ($urandom_range(0, 59) == 0);
            rvfi_valid_i     = ($urandom_range(0, 9) < 6);
            rvfi_pc_rdata_i  = ($urandom_range(0, 7) == 0) ? trig_pc_i
                                                           : 32'($urandom_range(0, 255)) << 2;
            rvfi_insn_i      = $urandom;
            rvfi_trap_i      = ($urandom_range(0, 9) == 0);
            rvfi_intr_i      = ($urandom_range(0, 9) == 0);
            rvfi_mode_i      = 2'($urandom_range(0, 3));
            rvfi_mem_addr_i  = $urandom;
            rvfi_mem_rmask_i = 4'($urandom_range(0, 15));
            rvfi_mem_wmask_i = 4'($urandom_range(0, 15));
            trig_now_i       = ($urandom_range(0, 49) == 0);
            rd_ready_i       = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 99) == 0) trig_mode_i = 2'($urandom_range(0, 3));
            cycle();
        end
        rst_i        = 1'b0;
        arm_i        = 1'b0;
        rvfi_valid_i = 1'b0;
        trig_now_i   = 1'b0;
        rd_ready_i   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_i            = 1'b1;
        rvfi_valid_i     = 1'b0;
        rvfi_pc_rdata_i  = '0;
        rvfi_insn_i      = '0;
        rvfi_trap_i      = 1'b0;
        rvfi_intr_i      = 1'b0;
        rvfi_mode_i      = '0;
        rvfi_mem_addr_i  = '0;
        rvfi_mem_rmask_i = '0;
        rvfi_mem_wmask_i = '0;
        arm_i            = 1'b0;
        trig_mode_i      = '0;
        trig_pc_i        = '0;
        trig_now_i       = 1'b0;
        rd_ready_i       = 1'b0;
        #2;
        test_reset();
        test_pc_match();
        test_wrap();
        test_intr();
        test_manual();
        test_back_to_back_stall();
        test_reset_in_post();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
